uart_rx: RTL and testbench

//  Serial receiver, counterpart of the uartTx transmitter on the same peripheral bus.
//  - Samples serialIn at 16x the bit rate, using rising edges of the shared baudClock.
//  - Assembles 8N1 frames and holds received bytes for the CPU.
//  - Bus interface: the same wire-OR'ed mem_* bus; outputs are zero when enable is low.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_rx_fifo.sv | 55 +++++
 rtl/uart_rx.sv | 243 ++++++++++++++++++++++++
 tb/tb_uart_rx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM encodings, STATUS bit
// positions, register offsets and the STATUS word packer.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    localparam int STAT_AVAIL = 0;
    localparam int STAT_OVR   = 1;
    localparam int STAT_FERR  = 2;
    localparam int STAT_FULL  = 3;

    localparam logic [31:0] REG_DATA   = 32'd0;
    localparam logic [31:0] REG_STATUS = 32'd4;

    function automatic logic [31:0] pack_status(
        input logic full,
        input logic ferr,
        input logic ovr,
        input logic avail
    );
        logic [31:0] word;
        word             = 32'd0;
        word[STAT_FULL]  = full;
        word[STAT_FERR]  = ferr;
        word[STAT_OVR]   = ovr;
        word[STAT_AVAIL] = avail;
        return word;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO, 2**AW entries. A push into a full FIFO is
// accepted only when a pop happens in the same cycle; otherwise it is dropped.
// The head entry is presented combinationally.
module uart_rx_fifo #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] head
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW:0]   wr_ptr_r;
    logic [AW:0]   rd_ptr_r;
    logic          do_push_s;
    logic          do_pop_s;

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign head      = mem_r[rd_ptr_r[AW-1:0]];

    // Storage array write; contents need no reset since the pointers gate visibility
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

    // Read/write pointer update
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver with 16x oversampling on the shared mem_* bus.
// Optional feature macro: UART_RX_FIFO_EN -- when defined, received bytes are
// queued in a 2**FIFO_AW deep FIFO; otherwise a single holding register is used.
// Read data is combinational and reflects the state in the request cycle;
// read side effects (pop, flag clear) take effect at the end of that cycle.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE   = 16,
    parameter int SAMPLE_POINT = 8,
    parameter int FIFO_AW      = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic        mem_instr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_addr,
    output logic [31:0] mem_rdata,
    input  logic        baudClock,
    input  logic        serialIn
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] SP_LAST = TW'(SAMPLE_POINT - 1);
    localparam logic [TW-1:0] OS_LAST = TW'(OVERSAMPLE - 1);

    rx_state_e   state_r;
    logic [TW-1:0] tcnt_r;
    logic [2:0]  bit_cnt_r;
    logic [7:0]  shift_r;
    logic        armed_r;
    logic        sync1_r;
    logic        rxs_r;
    logic        baud_q_r;
    logic        tick_s;
    logic        rdy_r;
    logic        first_s;
    logic        is_status_s;
    logic        push_s;
    logic        pop_s;
    logic        ovr_set_s;
    logic        ferr_set_s;
    logic        stat_clr_s;
    logic        overrun_r;
    logic        frame_err_r;
    logic        avail_s;
    logic        full_flag_s;
    logic [7:0]  head_s;
    logic [31:0] rdata_s;
    logic        unused_s;

    assign unused_s = ^{mem_instr, mem_wstrb, mem_wdata, mem_addr[31:3], mem_addr[1:0]};

    // Line synchronizer and baud clock edge history
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_r  <= 1'b1;
            rxs_r    <= 1'b1;
            baud_q_r <= 1'b0;
        end else begin
            sync1_r  <= serialIn;
            rxs_r    <= sync1_r;
            baud_q_r <= baudClock;
        end
    end

    assign tick_s = baudClock & ~baud_q_r;

    // Byte completes in the tick where the stop bit is sampled; a low stop bit is a framing error
    assign push_s     = tick_s && (state_r == ST_STOP) && (tcnt_r == OS_LAST);
    assign ferr_set_s = push_s & ~rxs_r;

    // Receive FSM: start-bit validation, LSB-first data shift, stop-bit sampling
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r   <= ST_IDLE;
            tcnt_r    <= {TW{1'b0}};
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'd0;
            armed_r   <= 1'b0;
        end else begin
            if (rxs_r) begin
                armed_r <= 1'b1;
            end
            if (tick_s) begin
                case (state_r)
                    ST_IDLE: begin
                        if (armed_r && !rxs_r) begin
                            state_r <= ST_START;
                            tcnt_r  <= {TW{1'b0}};
                        end
                    end
                    ST_START: begin
                        if (tcnt_r == SP_LAST) begin
                            if (rxs_r) begin
                                // Line back high at mid start bit: glitch, not a frame
                                state_r <= ST_IDLE;
                            end else begin
                                state_r   <= ST_DATA;
                                tcnt_r    <= {TW{1'b0}};
                                bit_cnt_r <= 3'd0;
                            end
                        end else begin
                            tcnt_r <= tcnt_r + {{(TW-1){1'b0}}, 1'b1};
                        end
                    end
                    ST_DATA: begin
                        if (tcnt_r == OS_LAST) begin
                            shift_r   <= {rxs_r, shift_r[7:1]};
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            tcnt_r    <= {TW{1'b0}};
                            if (bit_cnt_r == 3'd7) begin
                                state_r <= ST_STOP;
                            end
                        end else begin
                            tcnt_r <= tcnt_r + {{(TW-1){1'b0}}, 1'b1};
                        end
                    end
                    ST_STOP: begin
                        if (tcnt_r == OS_LAST) begin
                            state_r <= ST_IDLE;
                            tcnt_r  <= {TW{1'b0}};
                            if (!rxs_r) begin
                                // Break: wait for the line to return high before re-arming
                                armed_r <= 1'b0;
                            end
                        end else begin
                            tcnt_r <= tcnt_r + {{(TW-1){1'b0}}, 1'b1};
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        tcnt_r  <= {TW{1'b0}};
                    end
                endcase
            end
        end
    end

    // Bus acknowledge: one-cycle-delayed ready; side effects only on the first cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdy_r <= 1'b0;
        end else begin
            rdy_r <= mem_valid & enable;
        end
    end

    assign first_s     = mem_valid & enable & ~rdy_r;
    assign is_status_s = (mem_addr[2] == REG_STATUS[2]);
    assign pop_s       = first_s & ~is_status_s & avail_s;
    assign stat_clr_s  = first_s & is_status_s;
    assign mem_ready   = enable & rdy_r;

`ifdef UART_RX_FIFO_EN
    logic fifo_full_s;
    logic fifo_empty_s;

    uart_rx_fifo #(
        .AW (FIFO_AW),
        .DW (8)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push_s),
        .push_data (shift_r),
        .pop       (pop_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .head      (head_s)
    );

    assign avail_s     = ~fifo_empty_s;
    assign full_flag_s = fifo_full_s;
    assign ovr_set_s   = push_s & fifo_full_s & ~pop_s;
`else
    logic [7:0]         hold_r;
    logic               hold_valid_r;
    logic [FIFO_AW-1:0] unused_aw_s;

    assign unused_aw_s = {FIFO_AW{1'b0}};

    // Single-byte holding register; a push replaces the byte only when it is free or being read
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_r       <= 8'd0;
            hold_valid_r <= 1'b0;
        end else begin
            if (push_s && (!hold_valid_r || pop_s)) begin
                hold_r       <= shift_r;
                hold_valid_r <= 1'b1;
            end else if (pop_s) begin
                hold_valid_r <= 1'b0;
            end
        end
    end

    assign avail_s     = hold_valid_r;
    assign head_s      = hold_r;
    assign full_flag_s = hold_valid_r;
    assign ovr_set_s   = push_s & hold_valid_r & ~pop_s;
`endif

    // Sticky overrun and framing-error flags; a set beats a same-cycle status-read clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            if (ovr_set_s) begin
                overrun_r <= 1'b1;
            end else if (stat_clr_s) begin
                overrun_r <= 1'b0;
            end
            if (ferr_set_s) begin
                frame_err_r <= 1'b1;
            end else if (stat_clr_s) begin
                frame_err_r <= 1'b0;
            end
        end
    end

    // Read mux; zero when deselected so the bus can be wire-OR'ed
    always_comb begin
        rdata_s = 32'd0;
        if (!enable) begin
            rdata_s = 32'd0;
        end else if (is_status_s) begin
            rdata_s = pack_status(full_flag_s, frame_err_r, overrun_r, avail_s);
        end else if (avail_s) begin
            rdata_s = {24'd0, head_s};
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign mem_rdata = rdata_s;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: bus reads push their expected word into a
// queue; a monitor pops and compares on the first cycle of each access.
module tb_uart_rx;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic        mem_instr = 1'b0;
    logic [3:0]  mem_wstrb = 4'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_rdata;
    logic        baudClock = 1'b0;
    logic        serialIn = 1'b1;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];

    localparam logic [31:0] A_DATA = 32'd0;
    localparam logic [31:0] A_STAT = 32'd4;
`ifdef UART_RX_FIFO_EN
    localparam logic [31:0] T1_STAT  = 32'h1;
    localparam logic [31:0] RST_STAT = 32'h1;
`else
    localparam logic [31:0] T1_STAT  = 32'h9;
    localparam logic [31:0] RST_STAT = 32'hB;
`endif

    uart_rx dut (
        .clk       (clk),
        .resetn    (resetn),
        .enable    (enable),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_instr (mem_instr),
        .mem_wstrb (mem_wstrb),
        .mem_wdata (mem_wdata),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .baudClock (baudClock),
        .serialIn  (serialIn)
    );

    always #5 clk = ~clk;

    // baudClock period = 4 clk cycles, so 16 ticks/bit = 64 clk per bit
    initial begin
        forever begin
            repeat (2) @(posedge clk);
            #1 baudClock = ~baudClock;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: the request cycle (valid, selected, not yet ready) carries the read value
    always @(negedge clk) begin
        if (resetn && enable && mem_valid && !mem_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got 0x%08h expected no access", mem_rdata);
            end else begin
                check(name_q.pop_front(), mem_rdata, exp_q.pop_front());
            end
        end
    end

    task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string nm, input int hold);
        int n;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        enable    = 1'b1;
        mem_addr  = addr;
        mem_valid = 1'b1;
        n = 0;
        while (!mem_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!mem_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: ready=%0b required 1", nm, mem_ready);
        end
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        mem_valid = 1'b0;
        enable    = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) @(posedge baudClock);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_lvl, input int stop_ticks);
        serialIn = 1'b0;
        ticks(16);
        for (int i = 0; i < 8; i++) begin
            serialIn = b[i];
            ticks(16);
        end
        serialIn = stop_lvl;
        ticks(stop_ticks);
        serialIn = 1'b1;
        ticks(16);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        ticks(4);

        // Reset state
        bus_read(A_STAT, 32'h0, "reset_status", 0);
        bus_read(A_DATA, 32'h0, "reset_data_empty", 0);

        // 1: frame 0x55; deselected access sees zeros and has no side effect
        send_frame(8'h55, 1'b1, 16);
        @(posedge clk);
        #1;
        enable    = 1'b0;
        mem_addr  = A_DATA;
        mem_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("disabled_ready", {31'd0, mem_ready}, 32'd0);
            check("disabled_rdata", mem_rdata, 32'd0);
        end
        @(posedge clk);
        #1 mem_valid = 1'b0;
        bus_read(A_STAT, T1_STAT, "t1_status", 0);
        bus_read(A_DATA, 32'h55, "t1_data", 0);
        bus_read(A_STAT, 32'h0, "t1_status_after", 0);

        // 2: 4-tick glitch is rejected
        serialIn = 1'b0;
        ticks(4);
        serialIn = 1'b1;
        ticks(32);
        bus_read(A_STAT, 32'h0, "t2_glitch_status", 0);

        // 3: stop bit held low (break) for 40 ticks
        send_frame(8'hA3, 1'b0, 40);
        bus_read(A_DATA, 32'hA3, "t3_data", 0);
        bus_read(A_STAT, 32'h4, "t3_ferr_status", 0);
        bus_read(A_STAT, 32'h0, "t3_status_cleared", 0);

        // 4: two bytes without a read in between
        send_frame(8'h11, 1'b1, 16);
        send_frame(8'h22, 1'b1, 16);
        bus_read(A_DATA, 32'h11, "t4_data_first", 0);
`ifdef UART_RX_FIFO_EN
        bus_read(A_DATA, 32'h22, "t4_data_second", 0);
        bus_read(A_STAT, 32'h0, "t4_status", 0);
`else
        bus_read(A_STAT, 32'h2, "t4_overrun_status", 0);
        bus_read(A_STAT, 32'h0, "t4_status_cleared", 0);
`endif

`ifdef UART_RX_FIFO_EN
        // 5: 17 bytes into a 16-deep FIFO
        for (int i = 1; i <= 17; i++) begin
            send_frame(8'(i), 1'b1, 16);
        end
        bus_read(A_STAT, 32'hB, "t5_full_status", 0);
        for (int i = 1; i <= 16; i++) begin
            bus_read(A_DATA, 32'(i), "t5_fifo_order", 0);
        end
        bus_read(A_STAT, 32'h0, "t5_status_drained", 0);

        // 6: long-held DATA access pops exactly once
        send_frame(8'h7E, 1'b1, 16);
        send_frame(8'h7F, 1'b1, 16);
        bus_read(A_DATA, 32'h7E, "t6_held_read", 4);
        bus_read(A_DATA, 32'h7F, "t6_next_read", 0);
        bus_read(A_STAT, 32'h0, "t6_status", 0);
`else
        // 6: long-held DATA access pops exactly once
        send_frame(8'h7E, 1'b1, 16);
        bus_read(A_DATA, 32'h7E, "t6_held_read", 4);
        bus_read(A_DATA, 32'h0, "t6_empty_after", 0);
        send_frame(8'h7F, 1'b1, 16);
        bus_read(A_DATA, 32'h7F, "t6_next_read", 0);
`endif

        // Reset mid-frame with data and flags pending
        send_frame(8'h33, 1'b1, 16);
        send_frame(8'h44, 1'b1, 16);
        bus_read(A_STAT, RST_STAT, "pre_reset_status", 0);
        serialIn = 1'b0;
        ticks(16);
        serialIn = 1'b1;
        ticks(16);
        serialIn = 1'b0;
        ticks(8);
        @(posedge clk);
        #1;
        resetn   = 1'b0;
        serialIn = 1'b1;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        ticks(200);
        bus_read(A_STAT, 32'h0, "post_reset_status", 0);
        bus_read(A_DATA, 32'h0, "post_reset_data", 0);

        ticks(4);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
